// File: rtl/division_round_ctrl.sv
// Divisibility quiz sequencer: draws a dividend, presents it on a frame tick,
// scores the yes/no answer and tracks rounds and BCD score for one game.
// Ports:
//   clk, rst                  pixel clock, sync active-high reset
//   row, col                  VGA position (frame tick source)
//   start_btn/yes_btn/no_btn  synchronized button levels
//   dividend_tens/ones_value  BCD dividend shown on screen
//   score_tens/ones           BCD score
//   round_active/result_valid/result_correct/game_over  status
module division_round_ctrl #(
  parameter int unsigned DIVISOR        = 7,
  parameter int unsigned ROUNDS         = 10,
  parameter int unsigned TIMEOUT_FRAMES = 180,
  parameter int unsigned RESULT_FRAMES  = 60,
  parameter int unsigned FRAME_ROW      = 480,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] row,
  input  logic [9:0] col,
  input  logic       start_btn,
  input  logic       yes_btn,
  input  logic       no_btn,
  output logic [3:0] dividend_tens_value,
  output logic [3:0] dividend_ones_value,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic       round_active,
  output logic       result_valid,
  output logic       result_correct,
  output logic       game_over
);

  localparam logic [6:0] L_DIV     = 7'(DIVISOR);
  localparam logic [6:0] L_ROUNDS  = 7'(ROUNDS);
  localparam logic [7:0] L_TO_LAST = 8'(TIMEOUT_FRAMES - 1);
  localparam logic [7:0] L_RS_LAST = 8'(RESULT_FRAMES - 1);
  localparam logic [9:0] L_FROW    = 10'(FRAME_ROW);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAW, S_CONV, S_CHECK,
    S_PRESENT, S_WAIT, S_RESULT, S_OVER
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_lfsr;
  logic       r_start_q;
  logic       r_yes_q;
  logic       r_no_q;
  logic [6:0] r_work;
  logic [6:0] r_val;
  logic [3:0] r_tens_sh;
  logic [3:0] r_ones_sh;
  logic       r_div;
  logic [7:0] r_frames;
  logic [6:0] r_rounds;
  logic [3:0] r_dig_t;
  logic [3:0] r_dig_o;
  logic [3:0] r_sc_t;
  logic [3:0] r_sc_o;
  logic       r_correct;

  logic       w_tick;
  logic       w_start_e;
  logic       w_yes_e;
  logic       w_no_e;
  logic       w_ans;
  logic       w_hit;
  logic       w_expire;
  logic       w_res_done;
  logic       w_fb;
  logic [6:0] w_draw;

  assign w_tick     = (row == L_FROW) && (col == 10'd0);
  assign w_start_e  = start_btn & ~r_start_q;
  assign w_yes_e    = yes_btn & ~r_yes_q;
  assign w_no_e     = no_btn & ~r_no_q;
  assign w_ans      = w_yes_e | w_no_e;
  // both edges together always score as wrong
  assign w_hit      = (w_yes_e & ~w_no_e & r_div)
                    | (w_no_e & ~w_yes_e & ~r_div);
  assign w_expire   = w_tick && (r_frames == L_TO_LAST);
  assign w_res_done = w_tick && (r_frames == L_RS_LAST);
  assign w_fb       = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  // 7-bit draw folded once into 0..99
  assign w_draw     = (r_lfsr[6:0] >= 7'd100) ? r_lfsr[6:0] - 7'd100
                                              : r_lfsr[6:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_e) w_next = S_DRAW;
      S_DRAW:    w_next = S_CONV;
      S_CONV:    if (r_work < 7'd10) w_next = S_CHECK;
      S_CHECK:   if (r_work < L_DIV) w_next = S_PRESENT;
      S_PRESENT: if (w_tick) w_next = S_WAIT;
      S_WAIT:    if (w_ans || w_expire) w_next = S_RESULT;
      S_RESULT: begin
        if (w_res_done)
          w_next = (r_rounds == L_ROUNDS) ? S_OVER : S_DRAW;
      end
      S_OVER:    if (w_start_e) w_next = S_DRAW;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr    <= LFSR_SEED;
      r_start_q <= 1'b0;
      r_yes_q   <= 1'b0;
      r_no_q    <= 1'b0;
      r_work    <= '0;
      r_val     <= '0;
      r_tens_sh <= '0;
      r_ones_sh <= '0;
      r_div     <= 1'b0;
      r_frames  <= '0;
      r_rounds  <= '0;
      r_dig_t   <= '0;
      r_dig_o   <= '0;
      r_sc_t    <= '0;
      r_sc_o    <= '0;
      r_correct <= 1'b0;
    end else begin
      r_lfsr    <= {r_lfsr[6:0], w_fb};
      r_start_q <= start_btn;
      r_yes_q   <= yes_btn;
      r_no_q    <= no_btn;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_e) begin
            r_sc_t   <= '0;
            r_sc_o   <= '0;
            r_rounds <= '0;
          end
        end
        S_DRAW: begin
          r_work    <= w_draw;
          r_val     <= w_draw;
          r_tens_sh <= '0;
        end
        S_CONV: begin
          if (r_work >= 7'd10) begin
            r_work    <= r_work - 7'd10;
            r_tens_sh <= r_tens_sh + 4'd1;
          end else begin
            r_ones_sh <= r_work[3:0];
            r_work    <= r_val;
          end
        end
        S_CHECK: begin
          if (r_work >= L_DIV) r_work <= r_work - L_DIV;
          else                 r_div  <= (r_work == 7'd0);
        end
        S_PRESENT: begin
          if (w_tick) begin
            r_dig_t  <= r_tens_sh;
            r_dig_o  <= r_ones_sh;
            r_frames <= '0;
          end
        end
        S_WAIT: begin
          if (w_ans || w_expire) begin
            r_correct <= w_hit;
            r_frames  <= '0;
            r_rounds  <= r_rounds + 7'd1;
            if (w_hit && !(r_sc_t == 4'd9 && r_sc_o == 4'd9)) begin
              if (r_sc_o == 4'd9) begin
                r_sc_o <= 4'd0;
                r_sc_t <= r_sc_t + 4'd1;
              end else begin
                r_sc_o <= r_sc_o + 4'd1;
              end
            end
          end else if (w_tick) begin
            r_frames <= r_frames + 8'd1;
          end
        end
        S_RESULT: begin
          if (w_tick) r_frames <= r_frames + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign dividend_tens_value = r_dig_t;
  assign dividend_ones_value = r_dig_o;
  assign score_tens          = r_sc_t;
  assign score_ones          = r_sc_o;
  assign result_correct      = r_correct;
  assign round_active        = (r_state == S_WAIT);
  assign result_valid        = (r_state == S_RESULT);
  assign game_over           = (r_state == S_OVER);

endmodule

// File: tb/tb_division_round_ctrl.sv
// Randomized bench for division_round_ctrl against a round-level
// game model driven by its own LFSR copy and frame-tick bookkeeping.
module tb_division_round_ctrl;

  localparam int DIV  = 7;
  localparam int RND  = 3;
  localparam int TOF  = 4;
  localparam int RSF  = 2;
  localparam int FR   = 8;
  localparam int NCOL = 12;
  localparam int NROW = 10;
  localparam logic [7:0] SEED = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] row = '0;
  logic [9:0] col = '0;
  logic       start_btn = 1'b0;
  logic       yes_btn = 1'b0;
  logic       no_btn = 1'b0;
  logic [3:0] d_t, d_o, s_t, s_o;
  logic       act, val, cor, over;

  always #5 clk = ~clk;

  division_round_ctrl #(
    .DIVISOR(DIV), .ROUNDS(RND), .TIMEOUT_FRAMES(TOF),
    .RESULT_FRAMES(RSF), .FRAME_ROW(FR), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .start_btn(start_btn), .yes_btn(yes_btn), .no_btn(no_btn),
    .dividend_tens_value(d_t), .dividend_ones_value(d_o),
    .score_tens(s_t), .score_ones(s_o),
    .round_active(act), .result_valid(val),
    .result_correct(cor), .game_over(over)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr_nx(logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  typedef enum {P_IDLE, P_BUSY, P_WAIT, P_RES, P_OVER} ph_t;
  ph_t        ph = P_IDLE;
  logic [7:0] m_lfsr = SEED;
  int         cyc = 0;
  int         m_score = 0;
  int         m_rounds = 0;
  int         m_v = 0;
  int         draw_cyc = 0;
  int         wcnt = 0;
  int         rcnt = 0;
  bit         m_ok = 0;
  bit         hs = 0, hy = 0, hn = 0;
  logic [7:0] pd = '0;

  task automatic begin_draw();
    logic [6:0] s;
    s = m_lfsr[6:0];
    m_v = int'(s);
    if (m_v >= 100) m_v -= 100;
    draw_cyc = cyc;
    ph = P_BUSY;
  endtask

  task automatic enter_res();
    m_rounds++;
    if (m_ok && m_score < 99) m_score++;
    rcnt = 0;
    ph = P_RES;
    chk("res_enter", 32'({act, val}), 32'(2'b01));
    chk("res_correct", 32'(cor), 32'(m_ok));
    chk("res_score", 32'({s_t, s_o}), 32'(bcd(m_score)));
  endtask

  task automatic model(bit r, bit tk, bit es, bit ey, bit en);
    if (r) begin
      ph = P_IDLE;
      pd = '0;
      chk("reset_outs",
          32'({d_t, d_o, s_t, s_o, act, val, cor, over}), 32'(0));
      return;
    end
    if ({d_t, d_o} != pd) chk("dig_on_tick", 32'(tk), 32'(1));
    pd = {d_t, d_o};
    case (ph)
      P_IDLE, P_OVER: begin
        if (es) begin
          m_score = 0;
          m_rounds = 0;
          begin_draw();
          chk("start_clr", 32'({s_t, s_o, act, val, over}), 32'(0));
        end
      end
      P_BUSY: begin
        if (act) begin
          chk("present_tick", 32'(tk), 32'(1));
          chk("digits", 32'({d_t, d_o}), 32'(bcd(m_v)));
          ph = P_WAIT;
          wcnt = 0;
        end else if (tk && cyc - draw_cyc > 72) begin
          chk("present_late", 32'(act), 32'(1));
        end
      end
      P_WAIT: begin
        if (ey || en) begin
          if (ey && en) m_ok = 0;
          else if (ey)  m_ok = (m_v % DIV == 0);
          else          m_ok = (m_v % DIV != 0);
          enter_res();
        end else if (tk) begin
          wcnt++;
          if (wcnt == TOF) begin
            m_ok = 0;
            enter_res();
          end else begin
            chk("wait_hold", 32'({act, val}), 32'(2'b10));
          end
        end
      end
      P_RES: begin
        if (tk) begin
          rcnt++;
          if (rcnt == RSF) begin
            if (m_rounds == RND) begin
              ph = P_OVER;
              chk("over", 32'({val, over}), 32'(2'b01));
            end else begin
              begin_draw();
              chk("next_draw", 32'({val, over, act}), 32'(0));
            end
          end else begin
            chk("res_hold", 32'(val), 32'(1));
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic step();
    bit r, tk, es, ey, en;
    @(posedge clk);
    r  = rst;
    tk = (row == 10'(FR)) && (col == 10'd0);
    es = start_btn & ~hs;
    ey = yes_btn & ~hy;
    en = no_btn & ~hn;
    hs = r ? 1'b0 : start_btn;
    hy = r ? 1'b0 : yes_btn;
    hn = r ? 1'b0 : no_btn;
    m_lfsr = r ? SEED : lfsr_nx(m_lfsr);
    cyc++;
    @(negedge clk);
    model(r, tk, es, ey, en);
    if (col == 10'(NCOL - 1)) begin
      col = '0;
      row = (row == 10'(NROW - 1)) ? 10'd0 : row + 10'd1;
    end else begin
      col = col + 10'd1;
    end
  endtask

  task automatic wait_ph(ph_t p, int budget, string tag);
    int n;
    n = 0;
    while (ph != p && n < budget) begin
      step();
      n++;
    end
    chk({"reach_", tag}, 32'(ph == p), 32'(1));
  endtask

  task automatic start_game(int target);
    int n;
    logic [7:0] nx;
    n = 0;
    nx = lfsr_nx(m_lfsr);
    while (target >= 0 && int'(nx[6:0]) != target && n < 600) begin
      step();
      nx = lfsr_nx(m_lfsr);
      n++;
    end
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
  endtask

  // kind: 0 yes, 1 no, 2 both, 3 timeout, 4 right answer on expiring tick,
  // 5 yes held through the result into the next round
  task automatic play(int kind, int dly);
    int n;
    if (ph == P_BUSY) begin
      yes_btn = 1'b1;
      step();
      yes_btn = 1'b0;
    end
    wait_ph(P_WAIT, 400, "wait");
    case (kind)
      0, 1, 2, 5: begin
        repeat (dly) step();
        yes_btn = (kind != 1);
        no_btn  = (kind == 1 || kind == 2);
        step();
        no_btn = 1'b0;
        if (kind != 5) yes_btn = 1'b0;
      end
      3: begin
        repeat (50) step();
        start_btn = 1'b1;
        step();
        start_btn = 1'b0;
      end
      default: begin
        n = 0;
        while (!(wcnt == TOF - 1 && row == 10'(FR) && col == 10'd0)
               && n < 600) begin
          step();
          n++;
        end
        if (m_v % DIV == 0) yes_btn = 1'b1;
        else                no_btn = 1'b1;
        step();
        yes_btn = 1'b0;
        no_btn = 1'b0;
      end
    endcase
    wait_ph(P_RES, 600, "res");
    n = 0;
    while (ph == P_RES && n < 400) begin
      step();
      n++;
    end
    chk("res_exit", 32'(ph != P_RES), 32'(1));
    if (kind == 5 && ph == P_BUSY) begin
      wait_ph(P_WAIT, 400, "wait_held");
      repeat (120) step();
      chk("held_yes", 32'({act, val}), 32'(2'b10));
      yes_btn = 1'b0;
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    repeat (3 * NCOL * NROW) step();
    chk("idle_outs",
        32'({d_t, d_o, s_t, s_o, act, val, cor, over}), 32'(0));

    start_game(63);
    play(0, 130);
    chk("t63_digits", 32'({d_t, d_o}), 32'(8'h63));
    chk("t63_correct", 32'(cor), 32'(1));
    chk("t63_score", 32'({s_t, s_o}), 32'(8'h01));
    play(3, 0);
    chk("tmo_correct", 32'(cor), 32'(0));
    play(2, 40);
    chk("both_correct", 32'(cor), 32'(0));
    wait_ph(P_OVER, 400, "over1");
    chk("g1_over", 32'(over), 32'(1));
    chk("g1_score", 32'({s_t, s_o}), 32'(8'h01));

    start_game(63);
    play(1, 50);
    chk("no63_correct", 32'(cor), 32'(0));
    chk("no63_score", 32'({s_t, s_o}), 32'(8'h00));
    play(5, 30);
    play(4, 0);
    wait_ph(P_OVER, 400, "over2");

    start_game(107);
    play(0, 10);
    chk("t107_digits", 32'({d_t, d_o}), 32'(8'h07));
    wait_ph(P_WAIT, 400, "wait_rst");
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_wait_idle", 32'({act, s_t, s_o}), 32'(0));
    start_game(-1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    for (int g = 0; g < 4; g++) begin
      start_game(-1);
      for (int r = 0; r < RND; r++)
        play(int'($urandom_range(0, 4)), int'($urandom_range(0, 200)));
      wait_ph(P_OVER, 400, "over_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/division_round_ctrl.md
Name: division_round_ctrl

Overview:
- Game sequencer that replaces the hardwired dividend constants in the top level.
- Runs a fixed number of rounds. Each round it draws a pseudo-random dividend 0..99, splits it into BCD digits, and presents them to the dividend display at a frame boundary.
- The player answers "divisible by DIVISOR" (yes/no) before a frame-counted timeout. The block scores the answer and holds the result for a fixed time.
- Sits between the VGA timing (row/col) plus the button inputs, and the dividend/score display modules. Runs on the 25.1 MHz pixel clock.

Parameters:
- DIVISOR, 7, divisor under test (2..9).
- ROUNDS, 10, rounds per game (1..99).
- TIMEOUT_FRAMES, 180, frames allowed for an answer.
- RESULT_FRAMES, 60, frames the result is held before the next round.
- FRAME_ROW, 480, row at which the frame tick fires (first blanking line).
- LFSR_SEED, 8'hA5, LFSR value after reset (must be nonzero).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- row  in  10  current VGA row.
- col  in  10  current VGA column.
- start_btn  in  1  debounced/synchronized level.
- yes_btn  in  1  debounced/synchronized level.
- no_btn  in  1  debounced/synchronized level.
- dividend_tens_value  out  4  BCD tens to the display.
- dividend_ones_value  out  4  BCD ones to the display.
- score_tens  out  4  BCD.
- score_ones  out  4  BCD.
- round_active  out  1  high in WAIT_ANS.
- result_valid  out  1  high in RESULT.
- result_correct  out  1  last answer correct; meaningful when result_valid.
- game_over  out  1  high in OVER.

Behaviour:
- Reset:
  - All outputs are 0. State is IDLE. LFSR = LFSR_SEED.
  - Edge-detect history registers = 0. All counters = 0.
  - rst asserted in any state aborts the game at the next edge.
- Frame tick: one-cycle internal pulse when row==FRAME_ROW and col==0. Exactly one per frame.
- Buttons:
  - Rising-edge detect per button with a one-cycle pulse. A held level never re-fires.
  - Edges are ignored in any state that does not consume them.
- LFSR:
  - 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting every clock in all states.
  - Sampled once on entering DRAW.
- States:
  - IDLE: start edge -> DRAW. Score and round counter cleared on this transition.
  - DRAW (1 cycle): v = {1'b0, lfsr[6:0]}; if v>=100 then v -= 100. Gives 0..99. Go to CONV.
  - CONV: one subtraction per cycle. While w>=10: w -= 10, tens++. Then ones = w, r = v. Go to CHECK.
  - CHECK: while r>=DIVISOR: r -= DIVISOR, one per cycle. Then divisible = (r==0). Go to PRESENT. Worst case DRAW+CONV+CHECK is under 70 cycles.
  - PRESENT:
    - Wait for the next frame tick.
    - On that tick, load the shadow tens/ones into dividend_tens_value/dividend_ones_value, clear the frame counter, and go to WAIT_ANS.
    - Display digits change only on frame ticks, never mid-frame.
  - WAIT_ANS:
    - yes edge: correct = divisible.
    - no edge: correct = ~divisible.
    - yes and no edges in the same cycle: correct = 0.
    - Any answer -> RESULT, frame counter cleared.
    - If no answer arrives, frame counter increments on each tick. When it reaches TIMEOUT_FRAMES, correct = 0 -> RESULT.
    - An answer edge in the same cycle as the expiring tick wins.
  - RESULT:
    - On the entry cycle: if correct, the BCD score increments (ones wraps 9->0 with a tens carry; saturates at 99). Round counter increments.
    - After RESULT_FRAMES ticks: round counter == ROUNDS -> OVER, else -> DRAW.
  - OVER: dividend and score outputs hold. Start edge -> IDLE -> next cycle DRAW path. Equivalently, a start edge clears score and rounds, then goes to DRAW.
- Ignored edges: start edges outside IDLE/OVER are ignored. yes/no edges outside WAIT_ANS are ignored.
- Output timing: result_correct is registered and updates on RESULT entry. It holds through DRAW..WAIT_ANS until the next RESULT.
- Latency: from start edge to dividend update is at most 1 frame + 70 cycles.

Test Plan:
- Reset, then no input for 3 frames -> all outputs 0, state IDLE, no digit change.
- Force LFSR_SEED so the first draw gives v=63, DIVISOR=7; start, then yes edge in frame 2 -> digits 6/3 appear exactly on a frame tick, result_correct=1, score 0/1.
- Same draw (63), press no -> result_correct=0, score stays 0/0. Then a held yes level across RESULT produces no second scoring.
- No answer -> RESULT entered on tick 180 after presentation, result_correct=0. Check an answer edge coincident with tick 180 scores as an answer, not a timeout.
- ROUNDS=3, all correct -> score 0/3, game_over after the third RESULT_FRAMES. A start edge in OVER restarts with score 0/0. Start edges during WAIT_ANS are ignored.
- yes+no edges in the same cycle -> wrong. Assert rst mid-CONV and mid-WAIT_ANS -> all outputs 0 on the next edge, IDLE. Draw v=107 (lfsr[6:0]=107) -> digits 0/7.
